// File: rtl/pin_entry.sv
// Keypad PIN collector: assembles DIGITS BCD key codes into a packed word and
// presents it to the gate controller with a valid/ack handshake.
module pin_entry #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic                  key_ready,
  output logic [4*DIGITS-1:0]   pass,
  output logic                  pass_valid,
  input  logic                  pass_ack,
  input  logic                  lock_alarm,
  output logic [2:0]            digit_cnt,
  output logic                  entry_err,
  output logic                  timeout_err
);

  localparam int unsigned PW = 4 * DIGITS;
  localparam logic [3:0] K_CLEAR = 4'hA;
  localparam logic [3:0] K_BKSP  = 4'hB;
  localparam logic [3:0] K_ENTER = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PRESENT = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   buf_q, buf_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pass_valid_q, pass_valid_d;
  logic            entry_err_q, entry_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic            key_ready_q, key_ready_d;

  logic            accept;
  logic            is_digit;
  logic [PW-1:0]   buf_shift;

  assign accept    = key_valid && key_ready_q;
  assign is_digit  = (key_code <= 4'h9);
  assign buf_shift = {buf_q[PW-5:0], key_code};

  // Next-state and next-output decode; lock alarm overrides all key activity.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    pass_d        = pass_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    pass_valid_d  = pass_valid_q;
    entry_err_d   = 1'b0;
    timeout_err_d = 1'b0;

    if (lock_alarm) begin
      state_d      = S_LOCKED;
      pass_valid_d = 1'b0;
      buf_d        = '0;
      cnt_d        = '0;
      timer_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d = '0;
          if (accept) begin
            if (is_digit) begin
              buf_d   = buf_shift;
              cnt_d   = 3'd1;
              state_d = S_COLLECT;
            end else if (key_code == K_ENTER) begin
              entry_err_d = 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (accept) begin
            timer_d = '0;
            if (is_digit) begin
              // A full buffer silently swallows extra digits.
              if (cnt_q < 3'(DIGITS)) begin
                buf_d = buf_shift;
                cnt_d = cnt_q + 3'd1;
              end
            end else if (key_code == K_BKSP) begin
              buf_d = buf_q >> 4;
              cnt_d = cnt_q - 3'd1;
              if (cnt_q == 3'd1) begin
                state_d = S_IDLE;
              end
            end else if (key_code == K_CLEAR) begin
              buf_d   = '0;
              cnt_d   = '0;
              state_d = S_IDLE;
            end else if (key_code == K_ENTER) begin
              if (cnt_q == 3'(DIGITS)) begin
                pass_d       = buf_q;
                pass_valid_d = 1'b1;
                state_d      = S_PRESENT;
              end else begin
                entry_err_d = 1'b1;
                buf_d       = '0;
                cnt_d       = '0;
                state_d     = S_IDLE;
              end
            end
          end else if (timer_q == TW'(TIMEOUT)) begin
            timeout_err_d = 1'b1;
            buf_d         = '0;
            cnt_d         = '0;
            timer_d       = '0;
            state_d       = S_IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        S_PRESENT: begin
          if (pass_ack && pass_valid_q) begin
            pass_valid_d = 1'b0;
            buf_d        = '0;
            cnt_d        = '0;
            state_d      = S_IDLE;
          end
        end

        S_LOCKED: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    key_ready_d = (state_d == S_IDLE) || (state_d == S_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      buf_q         <= '0;
      pass_q        <= '0;
      cnt_q         <= '0;
      timer_q       <= '0;
      pass_valid_q  <= 1'b0;
      entry_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      key_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      pass_q        <= pass_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      pass_valid_q  <= pass_valid_d;
      entry_err_q   <= entry_err_d;
      timeout_err_q <= timeout_err_d;
      key_ready_q   <= key_ready_d;
    end
  end

  assign key_ready   = key_ready_q;
  assign pass        = pass_q;
  assign pass_valid  = pass_valid_q;
  assign digit_cnt   = cnt_q;
  assign entry_err   = entry_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pin_entry.sv
// Directed bench for pin_entry with a short timeout so expiry is reachable.
module tb_pin_entry;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [15:0] pass;
  logic        pass_valid;
  logic        pass_ack;
  logic        lock_alarm;
  logic [2:0]  digit_cnt;
  logic        entry_err;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  pin_entry #(.DIGITS(4), .TIMEOUT(10), .TW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .pass        (pass),
    .pass_valid  (pass_valid),
    .pass_ack    (pass_ack),
    .lock_alarm  (lock_alarm),
    .digit_cnt   (digit_cnt),
    .entry_err   (entry_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic ack();
    pass_ack = 1'b1;
    tick();
    pass_ack = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    key_valid  = 1'b0;
    key_code   = 4'h0;
    pass_ack   = 1'b0;
    lock_alarm = 1'b0;
    tick();
    rst = 1'b0;

    chk("rst_ready", 32'(key_ready), 32'd1);
    chk("rst_pass", 32'(pass), 32'h0);
    chk("rst_pv", 32'(pass_valid), 32'd0);
    chk("rst_cnt", 32'(digit_cnt), 32'd0);
    chk("rst_eerr", 32'(entry_err), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);

    // Basic entry and hold until ack
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("t1_cnt4", 32'(digit_cnt), 32'd4);
    press(4'hC);
    chk("t1_pass", 32'(pass), 32'h1234);
    chk("t1_pv", 32'(pass_valid), 32'd1);
    chk("t1_ready", 32'(key_ready), 32'd0);
    press(4'h5);
    repeat (4) tick();
    chk("t1_hold_pass", 32'(pass), 32'h1234);
    chk("t1_hold_pv", 32'(pass_valid), 32'd1);
    chk("t1_hold_ready", 32'(key_ready), 32'd0);
    chk("t1_hold_cnt", 32'(digit_cnt), 32'd4);
    ack();
    chk("t1_ack_pv", 32'(pass_valid), 32'd0);
    chk("t1_ack_ready", 32'(key_ready), 32'd1);
    chk("t1_ack_cnt", 32'(digit_cnt), 32'd0);
    chk("t1_ack_pass", 32'(pass), 32'h1234);

    // Fifth digit dropped
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
    chk("t2_sat_cnt", 32'(digit_cnt), 32'd4);
    press(4'hC);
    chk("t2_pass", 32'(pass), 32'h9876);
    ack();

    // Backspace mid-entry
    press(4'h1); press(4'h2); press(4'hB);
    chk("t2_bs_cnt", 32'(digit_cnt), 32'd1);
    press(4'h3); press(4'h4); press(4'h5); press(4'hC);
    chk("t2_bs_pass", 32'(pass), 32'h1345);
    chk("t2_bs_pv", 32'(pass_valid), 32'd1);
    ack();

    // Short entry, clear, and enter while idle
    press(4'h1); press(4'h2); press(4'hC);
    chk("t3_eerr", 32'(entry_err), 32'd1);
    chk("t3_cnt", 32'(digit_cnt), 32'd0);
    chk("t3_pv", 32'(pass_valid), 32'd0);
    tick();
    chk("t3_eerr_pulse", 32'(entry_err), 32'd0);
    press(4'h5);
    chk("t3_cnt1", 32'(digit_cnt), 32'd1);
    press(4'hA);
    chk("t3_clr_cnt", 32'(digit_cnt), 32'd0);
    chk("t3_clr_ready", 32'(key_ready), 32'd1);
    press(4'hC);
    chk("t3_idle_eerr", 32'(entry_err), 32'd1);

    // Timeout: timer reaches 10 ten edges after the key, fires on the next
    press(4'h7);
    repeat (10) tick();
    chk("t4_pre_terr", 32'(timeout_err), 32'd0);
    chk("t4_pre_cnt", 32'(digit_cnt), 32'd1);
    tick();
    chk("t4_terr", 32'(timeout_err), 32'd1);
    chk("t4_cnt", 32'(digit_cnt), 32'd0);
    tick();
    chk("t4_terr_pulse", 32'(timeout_err), 32'd0);

    // Key on the expiry cycle wins
    press(4'h7);
    repeat (10) tick();
    press(4'h8);
    chk("t4_win_terr", 32'(timeout_err), 32'd0);
    chk("t4_win_cnt", 32'(digit_cnt), 32'd2);
    tick();
    chk("t4_win_terr2", 32'(timeout_err), 32'd0);
    press(4'hA);

    // Lock alarm during collection
    press(4'h1); press(4'h2); press(4'h3);
    lock_alarm = 1'b1;
    tick();
    chk("t5_lock_ready", 32'(key_ready), 32'd0);
    chk("t5_lock_cnt", 32'(digit_cnt), 32'd0);
    press(4'h9); press(4'h9); press(4'h9);
    chk("t5_lock_keys_cnt", 32'(digit_cnt), 32'd0);
    chk("t5_lock_eerr", 32'(entry_err), 32'd0);
    lock_alarm = 1'b0;
    tick();
    chk("t5_unlock_ready", 32'(key_ready), 32'd1);
    press(4'h4); press(4'h3); press(4'h2); press(4'h1); press(4'hC);
    chk("t5_pass", 32'(pass), 32'h4321);
    chk("t5_pv", 32'(pass_valid), 32'd1);
    lock_alarm = 1'b1;
    tick();
    chk("t5_lock_pv", 32'(pass_valid), 32'd0);
    lock_alarm = 1'b0;
    tick();
    chk("t5_relock_ready", 32'(key_ready), 32'd1);

    // Reset during presentation, then stray ack in idle
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hC);
    chk("t6_pv", 32'(pass_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_pass", 32'(pass), 32'h0);
    chk("t6_rst_pv", 32'(pass_valid), 32'd0);
    chk("t6_rst_cnt", 32'(digit_cnt), 32'd0);
    chk("t6_rst_ready", 32'(key_ready), 32'd1);
    ack();
    chk("t6_ack_pv", 32'(pass_valid), 32'd0);
    chk("t6_ack_ready", 32'(key_ready), 32'd1);
    press(4'h5);
    chk("t6_idle_cnt", 32'(digit_cnt), 32'd1);
    press(4'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pin_entry.md
Name: pin_entry

Overview:
Keypad-side PIN collector that feeds the parking gate controller's 16-bit password input.
- Accepts one 4-bit key code per handshake and assembles DIGITS BCD digits into a packed word.
- On ENTER with a full buffer, presents the word with a valid/ack handshake.
- Clears and locks out keypad entry while the gate controller's lock alarm is asserted.

Parameters:
DIGITS, 4, number of BCD digits per PIN; pass width = 4*DIGITS.
TIMEOUT, 255, idle cycles allowed between accepted keys in COLLECT before the entry is aborted.
TW, 8, timeout counter width; must hold TIMEOUT.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
key_valid  in  1  keypad presents key_code this cycle
key_code  in  4  0x0-0x9 digit, 0xA CLEAR, 0xB BACKSPACE, 0xC ENTER, 0xD-0xF ignored
key_ready  out  1  block accepts a key this cycle
pass  out  4*DIGITS  assembled PIN, first digit in the most significant nibble
pass_valid  out  1  pass is valid, held until acknowledged
pass_ack  in  1  consumer took pass
lock_alarm  in  1  lock alarm from the gate controller
digit_cnt  out  3  digits currently buffered
entry_err  out  1  one-cycle pulse: ENTER pressed with fewer than DIGITS digits
timeout_err  out  1  one-cycle pulse: COLLECT aborted by timeout

Behaviour:
- Reset: synchronous, active-high. State IDLE. buffer=0, pass=0, digit_cnt=0, timer=0, pass_valid=0, entry_err=0, timeout_err=0. key_ready reads 1 on the first cycle after reset.
- Reset asserted mid-entry or mid-presentation discards everything. No pulse is emitted.
- A key is accepted only when key_valid && key_ready on the same edge. key_code outside an accepted cycle has no effect.
- key_ready is decoded from state: 1 in IDLE and COLLECT, 0 in PRESENT and LOCKED.
- All registered outputs update on the edge after the accepting cycle (latency 1).
- Priority per cycle: rst > lock_alarm > key handling / pass_ack > timeout.
- State IDLE:
  - digit: buffer={buffer[4*DIGITS-5:0], digit}, digit_cnt=1, go to COLLECT, timer=0.
  - CLEAR, BACKSPACE, ignored codes: no change.
  - ENTER: entry_err pulse, stay in IDLE.
- State COLLECT:
  - Every accepted key resets timer to 0. Otherwise timer increments by 1 per cycle.
  - digit with digit_cnt<DIGITS: shift the digit in, digit_cnt+1.
  - digit with digit_cnt==DIGITS: consumed and dropped; buffer and count unchanged.
  - BACKSPACE: buffer=buffer>>4, digit_cnt-1. If the result is 0, go to IDLE.
  - CLEAR: buffer=0, digit_cnt=0, go to IDLE.
  - ENTER with digit_cnt==DIGITS: pass<=buffer, pass_valid<=1, go to PRESENT.
  - ENTER with digit_cnt<DIGITS: entry_err pulse, buffer=0, digit_cnt=0, go to IDLE.
  - Codes 0xD-0xF: accepted, reset timer, otherwise ignored.
  - timer==TIMEOUT with no key accepted that cycle: timeout_err pulse, clear buffer and count, go to IDLE. A key accepted in the expiry cycle wins and the timeout does not fire.
- State PRESENT:
  - pass and pass_valid are held stable until pass_ack==1.
  - On ack: pass_valid<=0, buffer=0, digit_cnt=0, go to IDLE. pass keeps its last value.
  - pass_ack while pass_valid==0 is ignored in every state.
- State LOCKED:
  - Entered from any state on the edge where lock_alarm==1.
  - On entry: pass_valid<=0, buffer=0, digit_cnt=0, timer=0. No err pulses.
  - Stays in LOCKED while lock_alarm==1. Goes to IDLE on the first edge with lock_alarm==0.
- digit_cnt saturates at DIGITS, never wraps, and never goes below 0.

Test Plan:
- Reset, keys 1,2,3,4 then ENTER (0xC) -> pass=16'h1234 and pass_valid=1 one edge after ENTER. Hold ack low 5 cycles: pass/pass_valid stable and key_ready=0. ack=1 -> pass_valid=0 next edge, IDLE, key_ready=1.
- Keys 9,8,7,6,5 then ENTER -> pass=16'h9876 (fifth digit dropped). Keys 1,2,BACKSPACE,3,4,5 then ENTER -> pass=16'h1345.
- Keys 1,2 then ENTER -> entry_err high exactly 1 cycle, digit_cnt=0, pass_valid stays 0. Keys 5,CLEAR -> digit_cnt=0, IDLE.
- TIMEOUT=10: key 7 then idle -> timeout_err pulses on the cycle timer hits 10, digit_cnt=0. Repeat with a key on the expiry cycle -> no pulse, digit_cnt=2.
- Keys 1,2,3 then lock_alarm=1 for 4 cycles -> key_ready=0, digit_cnt=0, keys ignored. lock_alarm=0 -> IDLE; keys 4,3,2,1,ENTER -> pass=16'h4321. Also lock_alarm during PRESENT -> pass_valid drops next edge.
- rst=1 for one cycle while pass_valid=1 -> all outputs at reset values next edge. pass_ack pulse in IDLE -> no state change.
